dnn_layer_sequencer: RTL and testbench
======================================

# dnn_layer_sequencer

Sequences a chain of `dense_layer` instances through one inference and shares a single synchronous weight ROM (1-cycle read latency) between them. It issues one `start` pulse per layer in order and waits for each layer's `finish`. It steers the active layer's local `mem_addr` plus a per-layer base offset onto the ROM address, and reports done, error and cycle count to the top-level 1A2B control.

## Interface
- `NUM_LAYERS`, 3: number of chained layers, 1..4.
- `ADDR_WIDTH`, 12: width of each layer's local `mem_addr`.
- `ROM_ADDR_WIDTH`, 16: shared weight ROM address width.
- `BASE0`/`BASE1`/`BASE2`/`BASE3`, 0/0/0/0: ROM base offset of layer k; unused entries are ignored.
- `TIMEOUT`, 8191: maximum RUN cycles per layer before error; must be ≥ 1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  inference request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; takes priority over all other inputs except reset.
- `layer_finish`  in  NUM_LAYERS  per-layer finish pulse.
- `layer_addr`  in  NUM_LAYERS*ADDR_WIDTH  concatenated layer `mem_addr` buses; layer k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `layer_start`  out  NUM_LAYERS  one-hot start pulse to a layer.
- `rom_addr`  out  ROM_ADDR_WIDTH  shared ROM address.
- `active_layer`  out  2  index of the current layer.
- `busy`  out  1  high in LAUNCH and RUN.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `cycles`  out  16  cycles from accepted `start` to `done`/error, saturating at 0xFFFF.

## Operation
- States: IDLE, LAUNCH, RUN, DONE, ERROR. Reset puts the block in IDLE.
- Reset values: state IDLE, `cur`=0, all outputs 0.
- IDLE:
  - on `start`: `cur`←0, `cycles`←0, `error`←0, go to LAUNCH.
  - with `start` low: stay in IDLE.
- LAUNCH (exactly one cycle):
  - `layer_start[cur]`=1; all other `layer_start` bits are 0.
  - timeout counter ←0; go to RUN.
- RUN:
  - the counter increments each cycle.
  - on `layer_finish[cur]`: if `cur`==NUM_LAYERS-1, go to DONE; otherwise `cur`←`cur`+1 and go to LAUNCH.
  - otherwise, if counter==TIMEOUT, go to ERROR.
  - if finish and timeout occur in the same cycle, finish wins.
- DONE: `done`=1 for one cycle, then IDLE.
- ERROR: `error`←1 (held until the next accepted `start`), then IDLE. `done` is not asserted.
- Ignored inputs:
  - `layer_finish` bits other than `[cur]`, in any state.
  - any `layer_finish` in IDLE, LAUNCH, DONE and ERROR.
  - `start` outside IDLE; it is not queued.
- `abort` while busy: next state IDLE, no `done`, `error` unchanged, `layer_start` low. A layer already running is not stopped; its later `finish` is ignored.
- `rom_addr` (combinational) = `BASEk` + zero-extended `layer_addr[k]`, truncated to ROM_ADDR_WIDTH.
  - k=`cur` in LAUNCH/RUN.
  - k=0 in IDLE, DONE and ERROR, so layer 0's address 0 is presented before its start.
- `active_layer` = `cur`, zero-extended.
- `cycles` increments in LAUNCH, RUN, DONE and ERROR, saturating; it holds its value in IDLE.

## Timing
- Accepted `start` at cycle t: LAUNCH at t+1 with `layer_start[0]`=1 and `busy`=1.
- `layer_finish[cur]` at cycle f (not the last layer): `layer_start[cur+1]`=1 at f+1. `rom_addr` switches to `BASE(cur+1)`+`layer_addr` at f+1, which gives the ROM one cycle to fetch address 0 before the layer's first CALC cycle.
- Finish of the last layer at f: `done`=1 at f+1, `busy`=0 at f+1, IDLE at f+2. A new `start` is accepted at f+2.
- Timeout: `error`=1 from the cycle after the counter reaches TIMEOUT without a finish.
- Minimum inference length with layers finishing in their first RUN cycle: 2*NUM_LAYERS+1 cycles from `start` to `done`.
- `abort` at cycle a: IDLE at a+1.
- Reset mid-run: IDLE next cycle with all outputs 0, including `error`.

## Test plan
- Normal run: NUM_LAYERS=3, BASE=0/2080/2600, stub layers finish after 5/7/3 RUN cycles. `start` at cycle 10 -> `layer_start` = 001@11, 010@17, 100@25; `done`@29; `cycles`=19.
- ROM steering: in RUN with `cur`=1, drive `layer_addr[1]`=0x123 -> `rom_addr`=2080+0x123. In IDLE, `layer_addr[0]`=0 -> `rom_addr`=0.
- Timeout: TIMEOUT=4, layer 1 never finishes -> `error`=1 five cycles after its LAUNCH, no `done`, `busy`=0. The next `start` clears `error` at its LAUNCH.
- Spurious inputs: `layer_finish[2]` pulsed while `cur`=0 -> ignored. `start` pulsed during RUN -> ignored; exactly one `done`.
- Abort: `abort` during layer 1 RUN -> IDLE next cycle, no `done`. The late `layer_finish[1]` produces no `layer_start`.
- Simultaneous events: finish in the same cycle the counter hits TIMEOUT -> proceeds, no `error`. Reset asserted in RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dnn_layer_sequencer.sv
// dnn_layer_sequencer: launches chained dense layers in order and steers their
// local weight addresses onto one shared ROM through per-layer base offsets.
module dnn_layer_sequencer #(
   parameter int NUM_LAYERS     = 3,
   parameter int ADDR_WIDTH     = 12,
   parameter int ROM_ADDR_WIDTH = 16,
   parameter int BASE0          = 0,
   parameter int BASE1          = 0,
   parameter int BASE2          = 0,
   parameter int BASE3          = 0,
   parameter int TIMEOUT        = 8191
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             abort,
   input  logic [NUM_LAYERS-1:0]            layer_finish,
   input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_addr,
   output logic [NUM_LAYERS-1:0]            layer_start,
   output logic [ROM_ADDR_WIDTH-1:0]        rom_addr,
   output logic [1:0]                       active_layer,
   output logic                             busy,
   output logic                             done,
   output logic                             error,
   output logic [15:0]                      cycles
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, ERROR} state_t;
   state_t state, state_nx;
   logic [1:0] cur, sel;
   logic [CW-1:0] cnt;
   logic [3:0] fin4;
   logic fin, last, tout;
   logic [ADDR_WIDTH-1:0] la [4];
   genvar g;
   for (g = 0; g < 4; g++) begin : g_la
      if (g < NUM_LAYERS) begin : g_on
         assign la[g] = layer_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin : g_off
         assign la[g] = '0;
      end
   end
   assign fin4 = 4'(layer_finish);
   assign fin = fin4[cur];
   assign last = cur == 2'(NUM_LAYERS - 1);
   // cnt holds the number of the current RUN cycle, so a finish on the last allowed cycle still wins
   assign tout = cnt == CW'(TIMEOUT);
   assign active_layer = cur;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (start && !abort) ? LAUNCH : IDLE;
         LAUNCH:  state_nx = abort ? IDLE : RUN;
         RUN:     state_nx = abort ? IDLE : fin ? (last ? DONE : LAUNCH) : tout ? ERROR : RUN;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      busy = state == LAUNCH || state == RUN;
      done = state == DONE;
      layer_start = (state == LAUNCH && !abort) ? NUM_LAYERS'(4'b0001 << cur) : '0;
      sel = busy ? cur : 2'd0;
      rom_addr = ROM_ADDR_WIDTH'(sel == 2'd0 ? BASE0 : sel == 2'd1 ? BASE1 : sel == 2'd2 ? BASE2 : BASE3)
               + ROM_ADDR_WIDTH'(la[sel]);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur    <= '0;
         cnt    <= '0;
         cycles <= '0;
         error  <= 1'b0;
      end else begin
         if (state == IDLE && state_nx == LAUNCH) begin
            cur    <= '0;
            cycles <= '0;
            error  <= 1'b0;
         end else if (state != IDLE && cycles != 16'hFFFF) begin
            cycles <= cycles + 16'd1;
         end
         if (state == LAUNCH) cnt <= CW'(1);
         else if (state == RUN) cnt <= cnt + CW'(1);
         if (state == RUN && state_nx == LAUNCH) cur <= cur + 2'd1;
         if (state == RUN && state_nx == ERROR) error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// tb_dnn_layer_sequencer: randomized inferences against an event-time model of the
// sequencer; a negedge monitor pops expected levels and events from scoreboard queues.
module tb_dnn_layer_sequencer;
   localparam int TO = 8;
   localparam int B0 = 0, B1 = 2080, B2 = 2600;
   logic clk = 0, rst_n = 0, start = 0, abort = 0;
   logic [2:0] layer_finish = '0;
   logic [35:0] layer_addr = '0;
   logic [2:0] layer_start;
   logic [15:0] rom_addr, cycles;
   logic [1:0] active_layer;
   logic busy, done, error;
   int cyc = 0, n_vec = 0, n_err = 0, prev_cnt = 0;
   bit sb_on = 0, prev_err = 0;
   logic err_d = 0;
   typedef struct {logic [15:0] rom; logic busy; logic done; logic err; logic [15:0] cnt; logic [1:0] lay; bit chk_lay;} exp_t;
   typedef struct {int kind; int at; logic [2:0] val;} ev_t;
   exp_t cq[$];
   ev_t eq[$];

   dnn_layer_sequencer #(.NUM_LAYERS(3), .ADDR_WIDTH(12), .ROM_ADDR_WIDTH(16),
      .BASE0(B0), .BASE1(B1), .BASE2(B2), .BASE3(0), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .layer_finish(layer_finish), .layer_addr(layer_addr),
      .layer_start(layer_start), .rom_addr(rom_addr), .active_layer(active_layer),
      .busy(busy), .done(done), .error(error), .cycles(cycles));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_ev(input int kind, input logic [2:0] val);
      ev_t e;
      if (eq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_event kind %0d @cycle %0d, none required", kind, cyc);
      end else begin
         e = eq.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.at);
         chk("event_value", val, e.val);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_on && cq.size() > 0) begin
         e = cq.pop_front();
         chk("rom_addr", rom_addr, e.rom);
         chk("busy", busy, e.busy);
         chk("done", done, e.done);
         chk("error", error, e.err);
         chk("cycles", cycles, e.cnt);
         if (e.chk_lay) chk("active_layer", active_layer, e.lay);
      end
      if (sb_on) begin
         if (|layer_start) chk_ev(0, layer_start);
         if (done) chk_ev(1, 3'b0);
         if (error && !err_d) chk_ev(2, 3'b0);
      end
      err_d <= error;
   end

   function automatic logic [15:0] rom_of(input int j, input logic [35:0] la);
      return 16'((j == 0 ? B0 : j == 1 ? B1 : B2) + int'(la[j*12 +: 12]));
   endfunction

   function automatic logic [35:0] rand_la();
      return 36'({$urandom(), $urandom()});
   endfunction

   task automatic drive(input logic st, input logic ab, input logic [2:0] fin, input logic [35:0] la, input exp_t e);
      start = st;
      abort = ab;
      layer_finish = fin;
      layer_addr = la;
      cq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [35:0] la;
      exp_t e;
      repeat (n) begin
         la = rand_la();
         e = '{rom_of(0, la), 1'b0, 1'b0, prev_err, 16'(prev_cnt), 2'd0, 1'b0};
         drive(1'b0, 1'b0, 3'b0, la, e);
      end
   endtask

   // ab_mode: 0 none, 1 random busy cycle, 2 second RUN cycle of layer 1
   task automatic run_inf(input int idle_n, input int d0, input int d1, input int d2,
                          input int ab_mode, input bit spur, input int gap);
      int d[3], L[3], F[3];
      int t, E, a, X, k;
      bit fail, bsy;
      logic [35:0] la;
      logic [2:0] fin;
      exp_t e;
      d = '{d0, d1, d2};
      idle(idle_n);
      t = cyc;
      fail = 0;
      E = 0;
      for (int i = 0; i < 3; i++) begin
         L[i] = 1 << 30;
         F[i] = 1 << 30;
      end
      L[0] = t + 1;
      for (int i = 0; i < 3 && !fail; i++) begin
         if (d[i] > TO) begin
            fail = 1;
            E = L[i] + TO + 1;
         end else begin
            F[i] = L[i] + d[i];
            if (i == 2) E = F[i] + 1;
            else L[i+1] = F[i] + 1;
         end
      end
      a = ab_mode == 1 ? int'($urandom_range(E - 1, t + 1)) : ab_mode == 2 ? L[1] + 2 : 1 << 30;
      X = ab_mode != 0 ? a : E;
      for (int i = 0; i < 3; i++)
         if (L[i] < X) eq.push_back('{0, L[i], 3'(1 << i)});
      if (ab_mode == 0) eq.push_back('{fail ? 2 : 1, E, 3'b0});
      for (int c = t; c <= E + gap; c++) begin
         bsy = c > t && c < (ab_mode != 0 ? a + 1 : E);
         k = c >= L[2] ? 2 : c >= L[1] ? 1 : 0;
         la = rand_la();
         fin = '0;
         for (int i = 0; i < 3; i++)
            if (c == F[i]) fin[i] = 1'b1;
         if (spur) fin |= 3'($urandom()) & ~(bsy ? 3'(1 << k) : 3'b0);
         e.rom = rom_of(bsy ? k : 0, la);
         e.busy = bsy;
         e.done = ab_mode == 0 && !fail && c == E;
         e.err = c == t ? prev_err : (ab_mode == 0 && fail && c >= E);
         e.cnt = 16'(c == t ? prev_cnt : (c - t - 1 < X - t ? c - t - 1 : X - t));
         e.lay = 2'(k);
         e.chk_lay = bsy;
         drive(c == t || (spur && bsy && $urandom_range(3) == 0), c == a, fin, la, e);
      end
      prev_err = ab_mode == 0 && fail;
      prev_cnt = X - t;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_layer_start", layer_start, 0);
      chk("reset_error", error, 0);
      chk("reset_cycles", cycles, 0);
      chk("reset_active_layer", active_layer, 0);
      chk("reset_rom_addr", rom_addr, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      sb_on = 1;
      run_inf(10 - cyc, 5, 7, 3, 0, 0, 2);
      run_inf(1, 3, TO + 1, 1, 0, 0, 1);
      run_inf(0, TO, 2, TO, 0, 1, 0);
      run_inf(2, 4, 6, 2, 2, 0, 3);
      for (int n = 0; n < 40; n++)
         run_inf($urandom_range(3), $urandom_range(TO + 1, 1), $urandom_range(TO + 1, 1),
                 $urandom_range(TO + 1, 1), $urandom_range(4) == 0 ? 1 : 0,
                 1'($urandom_range(1)), $urandom_range(3));
      run_inf(1, 2, 2, TO + 1, 0, 1, 2);
      sb_on = 0;
      chk("pending_events", eq.size(), 0);
      chk("pending_levels", cq.size(), 0);
      start = 1;
      layer_addr = '0;
      layer_finish = '0;
      @(posedge clk);
      #1;
      start = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_before_reset", busy, 1);
      rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      chk("midrun_reset_busy", busy, 0);
      chk("midrun_reset_done", done, 0);
      chk("midrun_reset_layer_start", layer_start, 0);
      chk("midrun_reset_error", error, 0);
      chk("midrun_reset_cycles", cycles, 0);
      chk("midrun_reset_active_layer", active_layer, 0);
      chk("midrun_reset_rom_addr", rom_addr, 0);
      rst_n = 1;
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
